key_encoder: RTL and testbench



---
 rtl/key_encoder_if.sv | 26 ++
 rtl/key_encoder.sv | 107 ++++++++++
 tb/tb_key_encoder.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/key_encoder_if.sv
// Key encoder bus: raw key levels in, encoded/debounced key status out.
interface key_encoder_if;
  logic [7:0] key_in;
  logic [2:0] code;
  logic       valid;
  logic       key_evt;
  logic [7:0] press_cnt;

  // Key source side (board / testbench)
  modport master (
    output key_in,
    input  code,
    input  valid,
    input  key_evt,
    input  press_cnt
  );

  // Encoder side
  modport slave (
    input  key_in,
    output code,
    output valid,
    output key_evt,
    output press_cnt
  );
endinterface

// File: rtl/key_encoder.sv
// Sequential 8-to-3 priority key encoder: 2-flop synchronizer, whole-vector
// debounce, then a registered encode stage producing code/valid, a one-cycle
// press event and a wrapping press counter.
module key_encoder #(
  parameter int unsigned DB_CYCLES = 500000,
  parameter int unsigned CNT_W     = 20
) (
  input logic          clk,
  input logic          rst,
  key_encoder_if.slave bus
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

  // Synchronizer and debounce state
  logic [7:0]       sync1_q, sync2_q;
  logic [7:0]       cand_q, cand_d;
  logic [7:0]       stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Output stage state; stable_dly_q is the debounced vector one cycle late,
  // used to spot newly set bits.
  logic [7:0] stable_dly_q;
  logic [2:0] code_q, code_d;
  logic       valid_q, valid_d;
  logic       key_evt_q, key_evt_d;
  logic [7:0] press_cnt_q, press_cnt_d;
  logic [2:0] top_idx;

  // Two-flop synchronizer; key_in is never used combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= bus.key_in;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: any change restarts the count; stable only ever takes a
  // candidate that has held for DB_CYCLES consecutive cycles.
  always_comb begin
    cand_d   = cand_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = '0;
    end else if (cand_q != stable_q) begin
      if (cnt_q == DB_LAST) begin
        stable_d = cand_q;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d = '0;
    end
  end

  // Highest set bit of the debounced vector wins.
  always_comb begin
    top_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (stable_q[i]) top_idx = 3'(i);
    end
  end

  // Output next-state: outputs follow stable one edge later; code holds
  // when nothing is pressed; an event needs at least one newly set bit.
  always_comb begin
    valid_d     = |stable_q;
    code_d      = (|stable_q) ? top_idx : code_q;
    key_evt_d   = |(stable_q & ~stable_dly_q);
    press_cnt_d = press_cnt_q + {7'd0, key_evt_d};
  end

  // Debounce and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand_q       <= '0;
      stable_q     <= '0;
      cnt_q        <= '0;
      stable_dly_q <= '0;
      code_q       <= 3'd0;
      valid_q      <= 1'b0;
      key_evt_q    <= 1'b0;
      press_cnt_q  <= 8'd0;
    end else begin
      cand_q       <= cand_d;
      stable_q     <= stable_d;
      cnt_q        <= cnt_d;
      stable_dly_q <= stable_q;
      code_q       <= code_d;
      valid_q      <= valid_d;
      key_evt_q    <= key_evt_d;
      press_cnt_q  <= press_cnt_d;
    end
  end

  assign bus.code      = code_q;
  assign bus.valid     = valid_q;
  assign bus.key_evt   = key_evt_q;
  assign bus.press_cnt = press_cnt_q;

endmodule

// File: tb/tb_key_encoder.sv
// Bench for key_encoder: directed scenarios plus random key traffic, every
// cycle compared against a sample-window reference model.
module tb_key_encoder;
  localparam int DB = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  key_encoder_if bus ();

  key_encoder #(.DB_CYCLES(DB), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: the last DB+3 key samples (index 0 newest). The
  // debounced vector adopts a value once the samples two edges back and the
  // DB before them all agree; outputs reflect that vector one edge later.
  logic [7:0] hist [0:DB+2];
  logic [7:0] m_stable, m_prev;
  logic [2:0] m_code;
  logic       m_valid, m_evt;
  int         m_cnt;

  function automatic logic [2:0] top_index(input logic [7:0] v);
    logic [2:0] r = 3'd0;
    for (int i = 0; i < 8; i++) if (v[i]) r = 3'(i);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i <= DB + 2; i++) hist[i] = 8'd0;
    m_stable = 8'd0;
    m_prev   = 8'd0;
    m_code   = 3'd0;
    m_valid  = 1'b0;
    m_evt    = 1'b0;
    m_cnt    = 0;
  endtask

  task automatic model_edge(input logic [7:0] s);
    logic agree;
    m_evt   = |(m_stable & ~m_prev);
    m_valid = |m_stable;
    if (|m_stable) m_code = top_index(m_stable);
    if (m_evt) m_cnt = (m_cnt + 1) % 256;
    m_prev = m_stable;
    for (int i = DB + 2; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = s;
    agree = 1'b1;
    for (int i = 2; i <= DB + 2; i++) if (hist[i] != hist[2]) agree = 1'b0;
    if (agree) m_stable = hist[2];
  endtask

  // One clock: the model consumes the key level seen at the edge, then all
  // outputs are compared 1ns later.
  task automatic tick();
    @(posedge clk);
    model_edge(bus.key_in);
    #1;
    chk("code",      {5'd0, bus.code},    {5'd0, m_code});
    chk("valid",     {7'd0, bus.valid},   {7'd0, m_valid});
    chk("key_evt",   {7'd0, bus.key_evt}, {7'd0, m_evt});
    chk("press_cnt", bus.press_cnt,       8'(m_cnt));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Reset asserted between edges; outputs must clear without a clock edge.
  task automatic apply_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_code",      {5'd0, bus.code},    8'd0);
    chk("rst_valid",     {7'd0, bus.valid},   8'd0);
    chk("rst_key_evt",   {7'd0, bus.key_evt}, 8'd0);
    chk("rst_press_cnt", bus.press_cnt,       8'd0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  int evt_n, evt_at, fall_at, gap_n, cnt0, hold;
  logic [7:0] v;

  initial begin
    bus.key_in = 8'd0;
    model_reset();
    apply_reset();

    // 1: reset in the middle of a debounce count
    bus.key_in = 8'h10;
    ticks(3);
    apply_reset();
    bus.key_in = 8'h00;
    evt_n = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.key_evt) evt_n++;
    end
    chk("s1_no_evt", 8'(evt_n), 8'd0);
    chk("s1_valid", {7'd0, bus.valid}, 8'd0);

    // 2: single press, latency of 7 edges from the sampling edge
    bus.key_in = 8'h08;
    evt_n = 0; evt_at = -1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.key_evt) begin evt_n++; evt_at = i; end
    end
    chk("s2_evt_latency", 8'(evt_at), 8'd7);
    chk("s2_evt_count", 8'(evt_n), 8'd1);
    chk("s2_code", {5'd0, bus.code}, 8'd3);
    chk("s2_press_cnt", bus.press_cnt, 8'd1);
    bus.key_in = 8'h00;
    evt_n = 0; fall_at = -1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.key_evt) evt_n++;
      if (!bus.valid && fall_at < 0) fall_at = i;
    end
    chk("s2_release_latency", 8'(fall_at), 8'd7);
    chk("s2_release_no_evt", 8'(evt_n), 8'd0);
    chk("s2_code_held", {5'd0, bus.code}, 8'd3);

    // reset while a key is held and valid: clears at once, then re-debounces
    bus.key_in = 8'h20;
    ticks(10);
    apply_reset();
    ticks(12);
    chk("s2r_code", {5'd0, bus.code}, 8'd5);
    chk("s2r_press_cnt", bus.press_cnt, 8'd1);
    bus.key_in = 8'h00;
    ticks(12);
    apply_reset();

    // 3: bounce shorter than the debounce window
    evt_n = 0;
    for (int i = 0; i < 10; i++) begin
      bus.key_in = (i % 2 == 0) ? 8'h02 : 8'h00;
      for (int k = 0; k < 2; k++) begin
        tick();
        if (bus.key_evt || bus.valid) evt_n++;
      end
    end
    bus.key_in = 8'h00;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.key_evt || bus.valid) evt_n++;
    end
    chk("s3_no_activity", 8'(evt_n), 8'd0);
    chk("s3_press_cnt", bus.press_cnt, 8'd0);

    // 4: priority and multi-key
    evt_n = 0;
    bus.key_in = 8'h01;
    for (int i = 0; i < 12; i++) begin tick(); if (bus.key_evt) evt_n++; end
    chk("s4_code0", {5'd0, bus.code}, 8'd0);
    bus.key_in = 8'h41;
    for (int i = 0; i < 12; i++) begin tick(); if (bus.key_evt) evt_n++; end
    chk("s4_code6", {5'd0, bus.code}, 8'd6);
    chk("s4_two_evts", 8'(evt_n), 8'd2);
    bus.key_in = 8'h01;
    for (int i = 0; i < 12; i++) begin tick(); if (bus.key_evt) evt_n++; end
    chk("s4_drop_code", {5'd0, bus.code}, 8'd0);
    chk("s4_drop_no_evt", 8'(evt_n), 8'd2);
    chk("s4_drop_valid", {7'd0, bus.valid}, 8'd1);
    bus.key_in = 8'h00;
    ticks(12);

    // 5: counter wrap from zero
    apply_reset();
    for (int r = 0; r < 256; r++) begin
      bus.key_in = 8'h80;
      ticks(10);
      bus.key_in = 8'h00;
      ticks(10);
    end
    chk("s5_wrap", bus.press_cnt, 8'd0);
    chk("s5_code", {5'd0, bus.code}, 8'd7);

    // 6: direct swap, no valid gap
    bus.key_in = 8'h04;
    ticks(12);
    cnt0 = int'(bus.press_cnt);
    bus.key_in = 8'h08;
    evt_n = 0; gap_n = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.key_evt) evt_n++;
      if (!bus.valid) gap_n++;
    end
    chk("s6_one_evt", 8'(evt_n), 8'd1);
    chk("s6_no_gap", 8'(gap_n), 8'd0);
    chk("s6_code", {5'd0, bus.code}, 8'd3);
    chk("s6_press_cnt", bus.press_cnt, 8'((cnt0 + 1) % 256));

    // random traffic: mixed glitch/hold lengths, sparse vectors, rare resets
    for (int r = 0; r < 400; r++) begin
      v = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 2) == 0) v = v & 8'($urandom_range(0, 255));
      bus.key_in = v;
      hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : int'($urandom_range(5, 10));
      ticks(hold);
      if ($urandom_range(0, 60) == 0) apply_reset();
    end
    bus.key_in = 8'h00;
    ticks(12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
